// File: rtl/imem_pkg.sv
// Shared types and default widths for the instruction-memory stream loader.
package imem_pkg;
    localparam int BYTE_W     = 8;
    localparam int DEF_LANES  = 4;
    localparam int DEF_ADDR_W = 9;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} loader_state_e;
endpackage

// File: rtl/imem_port_mux.sv
// Selects who drives the byte-lane SRAM macros: the boot loader or the core fetch path.
module imem_port_mux
    import imem_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     sel_core,
    input  logic [LANES-1:0]         l_cen,
    input  logic [LANES-1:0]         l_gwen,
    input  logic [LANES*BYTE_W-1:0]  l_wen,
    input  logic [LANES*ADDR_W-1:0]  l_a,
    input  logic [LANES*BYTE_W-1:0]  l_d,
    input  logic [LANES-1:0]         c_cen,
    input  logic [LANES-1:0]         c_gwen,
    input  logic [LANES*BYTE_W-1:0]  c_wen,
    input  logic [LANES*ADDR_W-1:0]  c_a,
    input  logic [LANES*BYTE_W-1:0]  c_d,
    output logic [LANES-1:0]         m_cen,
    output logic [LANES-1:0]         m_gwen,
    output logic [LANES*BYTE_W-1:0]  m_wen,
    output logic [LANES*ADDR_W-1:0]  m_a,
    output logic [LANES*BYTE_W-1:0]  m_d
);
    assign m_cen  = sel_core ? c_cen  : l_cen;
    assign m_gwen = sel_core ? c_gwen : l_gwen;
    assign m_wen  = sel_core ? c_wen  : l_wen;
    assign m_a    = sel_core ? c_a    : l_a;
    assign m_d    = sel_core ? c_d    : l_d;
endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: packs a valid/ready byte stream into LANES-byte words, writes them to the
// instruction macros, then releases the macros and the core reset.
module imem_stream_loader
    import imem_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [CNT_W-1:0]         len_words,
    input  logic                     in_valid,
    input  logic [BYTE_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     core_hold,
    output logic [BYTE_W-1:0]        checksum,
    input  logic [LANES-1:0]         c_cen,
    input  logic [LANES-1:0]         c_gwen,
    input  logic [LANES*BYTE_W-1:0]  c_wen,
    input  logic [LANES*ADDR_W-1:0]  c_a,
    input  logic [LANES*BYTE_W-1:0]  c_d,
    output logic [LANES*BYTE_W-1:0]  c_q,
    output logic [LANES-1:0]         m_cen,
    output logic [LANES-1:0]         m_gwen,
    output logic [LANES*BYTE_W-1:0]  m_wen,
    output logic [LANES*ADDR_W-1:0]  m_a,
    output logic [LANES*BYTE_W-1:0]  m_d,
    input  logic [LANES*BYTE_W-1:0]  m_q
);
    localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(2 ** ADDR_W);

    loader_state_e             state;
    logic [LANE_W-1:0]         lane_q;
    logic [CNT_W-1:0]          word_q;
    logic [CNT_W-1:0]          word_nxt;
    logic [CNT_W-1:0]          n_words;
    logic [CNT_W-1:0]          n_sat;
    logic [LANES*BYTE_W-1:0]   word_buf;
    logic                      accept;

    logic [LANES-1:0]          l_cen;
    logic [LANES-1:0]          l_gwen;
    logic [LANES*BYTE_W-1:0]   l_wen;
    logic [LANES*ADDR_W-1:0]   l_a;
    logic [LANES*BYTE_W-1:0]   l_d;

    assign n_sat    = (len_words > DEPTH) ? DEPTH : len_words;
    assign word_nxt = word_q + 1'b1;
    assign accept   = (state == FILL) && in_valid && in_ready;
    assign c_q      = m_q;

    // in_ready is kept as a register that mirrors "state == FILL" so it never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            core_hold <= 1'b1;
            in_ready  <= 1'b0;
            checksum  <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            n_words   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        word_q   <= '0;
                        lane_q   <= '0;
                        checksum <= '0;
                        n_words  <= n_sat;
                        if (len_words == '0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                            in_ready  <= 1'b0;
                        end else begin
                            state     <= FILL;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            core_hold <= 1'b1;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        checksum <= checksum + in_data;
                        if (lane_q == LAST_LANE) begin
                            lane_q   <= '0;
                            state    <= WRITE;
                            in_ready <= 1'b0;
                        end else begin
                            lane_q <= lane_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    word_q <= word_nxt;
                    if (word_nxt == n_words) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Word assembly buffer is pure data; only complete words ever reach the macros.
    always_ff @(posedge clk) begin
        if (accept)
            word_buf[lane_q*BYTE_W +: BYTE_W] <= in_data;
    end

    always_comb begin
        l_cen  = '1;
        l_gwen = '1;
        l_wen  = '1;
        l_a    = '0;
        l_d    = '0;
        if (state == WRITE) begin
            l_cen  = '0;
            l_gwen = '0;
            l_wen  = '0;
            l_a    = {LANES{word_q[ADDR_W-1:0]}};
            l_d    = word_buf;
        end
    end

    imem_port_mux #(
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) u_port_mux (
        .sel_core (state == DONE),
        .l_cen    (l_cen),
        .l_gwen   (l_gwen),
        .l_wen    (l_wen),
        .l_a      (l_a),
        .l_d      (l_d),
        .c_cen    (c_cen),
        .c_gwen   (c_gwen),
        .c_wen    (c_wen),
        .c_a      (c_a),
        .c_d      (c_d),
        .m_cen    (m_cen),
        .m_gwen   (m_gwen),
        .m_wen    (m_wen),
        .m_a      (m_a),
        .m_d      (m_d)
    );
endmodule
